// File: rtl/par_seri_sched.sv
// Round-robin scheduler sharing one parallel-to-serial shifter among requesters.
// Arbitrates in IDLE, pulses ld with ack, then holds en for WIDTH shift cycles.
module par_seri_sched #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  parameter int GAP   = 1,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       ack,
  output logic                  ld,
  output logic                  en,
  output logic [WIDTH-1:0]      pi,
  output logic                  busy,
  output logic [IW-1:0]         gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP
  } state_t;

  localparam int GW = 2;
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t            state_q;
  logic [IW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [GW-1:0]     gcnt_q;
  logic [NREQ-1:0]   ack_q;
  logic              ld_q;
  logic              en_q;
  logic [WIDTH-1:0]  pi_q;
  logic              busy_q;
  logic [IW-1:0]     gnt_q;

  logic [IW-1:0]     pick_d;
  logic [NREQ-1:0]   ack_d;
  logic [WIDTH-1:0]  word_d;
  logic              hit;

  // Circular search starting just after the last winner.
  always_comb begin
    pick_d = ptr_q;
    hit    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!hit && req[(int'(ptr_q) + i) % NREQ]) begin
        hit    = 1'b1;
        pick_d = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    ack_d         = '0;
    ack_d[pick_d] = 1'b1;
    word_d        = din[pick_d*WIDTH +: WIDTH];
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
      gcnt_q  <= '0;
      ack_q   <= '0;
      ld_q    <= 1'b0;
      en_q    <= 1'b0;
      pi_q    <= '0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
    end else begin
      ack_q <= '0;
      ld_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (|req) begin
            pi_q    <= word_d;
            gnt_q   <= pick_d;
            ptr_q   <= pick_d;
            ack_q   <= ack_d;
            ld_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          en_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (cnt_q == CLAST) begin
            en_q <= 1'b0;
            if (GAP > 0) begin
              gcnt_q  <= '0;
              state_q <= S_GAP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt_q == GLAST) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack    = ack_q;
  assign ld     = ld_q;
  assign en     = en_q;
  assign pi     = pi_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;

endmodule
